// File: rtl/fifo_wr_arbiter.sv
// Round-robin sequencer sharing one FIFO write port; a grant lasts up to MAX_BURST words, first word in the cycle after the grant edge.
// Backpressure: the synchronised almost-full flag parks the owner in HOLD and keeps its grant; requesters advance their data only on ack.
module fifo_wr_arbiter #(
  parameter int NREQ        = 4,
  parameter int DSIZE       = 8,
  parameter int MAX_BURST   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    wclk,
  input  logic                    dirclr_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   wdata_in,
  input  logic                    afull_n,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          prio_q, prio_d;
  logic [BW-1:0]          burst_q, burst_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [IW-1:0]          scan, pick;
  logic                   pick_vld, afull_s, own_req, wr;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    return v + IW'(1);
  endfunction

  // Reset to 0 so the FIFO is treated as full until afull_n has crossed over.
  always_ff @(posedge wclk or negedge dirclr_n) begin
    if (!dirclr_n) sync_q <= '0;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], afull_n};
  end

  assign afull_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    pick_vld = 1'b0;
    pick     = prio_q;
    scan     = prio_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req[scan]) begin
        pick_vld = 1'b1;
        pick     = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  assign own_req = req[owner_q];
  assign wr      = (state_q == XFER) && own_req && afull_s;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    burst_d = burst_q;
    winc    = 1'b0;
    ack     = '0;
    wdata   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld && afull_s) begin
          state_d     = XFER;
          owner_d     = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          burst_d     = '0;
        end
      end
      XFER: begin
        if (wr) begin
          winc         = 1'b1;
          ack[owner_q] = 1'b1;
          wdata        = wdata_in[int'(owner_q)*DSIZE +: DSIZE];
          burst_d      = burst_q + BW'(1);
        end
        if ((wr && burst_q == LAST_BEAT) || !own_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          burst_d = '0;
          prio_d  = wrap_inc(owner_q);
        end else if (!afull_s) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // burst_cnt is kept so a stalled grant still ends after MAX_BURST words.
        if (!own_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          burst_d = '0;
          prio_d  = wrap_inc(owner_q);
        end else if (afull_s) begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge dirclr_n) begin
    if (!dirclr_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      prio_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      burst_q <= burst_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requesters are modelled in the bench and advance data on ack;
// each scenario is a per-cycle table of expected gnt/winc/wdata, cycle 1 being the first edge after reset release.
module tb_fifo_wr_arbiter;

  localparam int NREQ        = 4;
  localparam int DSIZE       = 8;
  localparam int MAX_BURST   = 4;
  localparam int SYNC_STAGES = 2;

  logic                  wclk = 1'b0;
  logic                  dirclr_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] wdata_in;
  logic                  afull_n;
  logic [NREQ-1:0]       gnt, ack;
  logic                  winc, busy;
  logic [DSIZE-1:0]      wdata;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .wclk(wclk), .dirclr_n(dirclr_n), .req(req), .wdata_in(wdata_in), .afull_n(afull_n),
    .gnt(gnt), .ack(ack), .winc(winc), .wdata(wdata), .busy(busy)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;
  int rem[NREQ];
  int sent[NREQ];
  int tg[$], tw[$], td[$];
  int nw;

  logic [NREQ-1:0]  s_gnt, s_ack;
  logic             s_winc, s_busy;
  logic [DSIZE-1:0] s_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rem[i] > 0);
      wdata_in[i*DSIZE +: DSIZE] = DSIZE'(i*32 + sent[i]);
    end
  endtask

  // One clock: requesters consume the previous cycle's ack, then outputs are sampled at the falling edge.
  task automatic step();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (s_ack[i]) begin
        sent[i]++;
        rem[i]--;
      end
    end
    drive();
    @(negedge wclk);
    s_gnt   = gnt;
    s_ack   = ack;
    s_winc  = winc;
    s_busy  = busy;
    s_wdata = wdata;
  endtask

  task automatic do_reset(input logic af, input bit clr);
    dirclr_n = 1'b0;
    afull_n  = af;
    s_ack    = '0;
    if (clr) begin
      for (int i = 0; i < NREQ; i++) begin
        rem[i]  = 0;
        sent[i] = 0;
      end
    end
    drive();
    #1;
    chk("reset gnt",   32'(gnt),   32'h0);
    chk("reset winc",  32'(winc),  32'h0);
    chk("reset ack",   32'(ack),   32'h0);
    chk("reset busy",  32'(busy),  32'h0);
    chk("reset wdata", 32'(wdata), 32'h0);
    @(posedge wclk);
    @(posedge wclk);
    #1;
    dirclr_n = 1'b1;
  endtask

  task automatic chk_cyc(input string tag, input int c, input int eg, input int ew, input int ed);
    chk($sformatf("%s c%0d gnt", tag, c),   32'(s_gnt),   32'(eg));
    chk($sformatf("%s c%0d winc", tag, c),  32'(s_winc),  32'(ew));
    chk($sformatf("%s c%0d ack", tag, c),   32'(s_ack),   (ew != 0) ? 32'(eg) : 32'h0);
    chk($sformatf("%s c%0d wdata", tag, c), 32'(s_wdata), (ew != 0) ? 32'(ed) : 32'h0);
    chk($sformatf("%s c%0d busy", tag, c),  32'(s_busy),  32'(eg != 0));
  endtask

  // Runs the tg/tw/td table; afull_n falls after cycle lo_c and rises after cycle hi_c.
  task automatic run_tbl(input string tag, input int lo_c, input int hi_c, output int wcnt);
    wcnt = 0;
    for (int c = 1; c <= tg.size(); c++) begin
      step();
      if (c == lo_c) afull_n = 1'b0;
      if (c == hi_c) afull_n = 1'b1;
      if (s_winc) wcnt++;
      chk_cyc(tag, c, tg[c-1], tw[c-1], td[c-1]);
    end
  endtask

  initial begin
    req      = '0;
    wdata_in = '0;
    s_ack    = '0;

    // Single requester, 10 words: bursts of 4, 4, 2 with one idle cycle between.
    do_reset(1'b1, 1'b1);
    rem[2] = 10;
    tg = '{0, 0, 4, 4, 4, 4, 0, 4, 4, 4, 4, 0, 4, 4, 4, 0};
    tw = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    td = '{0, 0, 64, 65, 66, 67, 0, 68, 69, 70, 71, 0, 72, 73, 0, 0};
    run_tbl("single", -1, -1, nw);
    chk("single total winc", 32'(nw), 32'd10);

    // Full contention: owners 0,1,2,3,0, four words each.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < NREQ; i++) rem[i] = 8;
    nw = 0;
    for (int c = 1; c <= 26; c++) begin
      int k, o, eg, ew, ed;
      step();
      eg = 0; ew = 0; ed = 0;
      if (c >= 3) begin
        k = (c - 3) % 5;
        if (k != 4) begin
          o  = ((c - 3) / 5) % 4;
          eg = 1 << o;
          ew = 1;
          ed = o*32 + ((c - 3) / 20)*4 + k;
        end
      end
      if (s_winc) nw++;
      chk_cyc("contend", c, eg, ew, ed);
    end
    chk("contend total winc", 32'(nw), 32'd20);

    // Almost-full during a burst: HOLD keeps the grant, remaining 2 words follow.
    do_reset(1'b1, 1'b1);
    rem[0] = 4;
    tg = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    tw = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    td = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 3, 0};
    run_tbl("stall", 3, 8, nw);
    chk("stall total winc", 32'(nw), 32'd4);

    // Early release by requester 1: priority moves to 2, so 3 wins over 0.
    do_reset(1'b1, 1'b1);
    rem[1] = 1;
    step(); chk_cyc("early", 1, 0, 0, 0);
    step(); chk_cyc("early", 2, 0, 0, 0);
    step(); chk_cyc("early", 3, 2, 1, 32);
    rem[0] = 4;
    rem[3] = 4;
    tg = '{2, 0, 8, 8, 8, 8, 0, 1};
    tw = '{0, 0, 1, 1, 1, 1, 0, 1};
    td = '{0, 0, 96, 97, 98, 99, 0, 0};
    run_tbl("early+3", -1, -1, nw);

    // Reset mid-burst: the in-flight word is not acked and is resent after resync.
    do_reset(1'b1, 1'b1);
    rem[2] = 8;
    tg = '{0, 0, 4, 4};
    tw = '{0, 0, 1, 1};
    td = '{0, 0, 64, 65};
    run_tbl("midrst pre", -1, -1, nw);
    #1;
    do_reset(1'b1, 1'b0);
    tg = '{0, 0, 4};
    tw = '{0, 0, 1};
    td = '{0, 0, 65};
    run_tbl("midrst post", -1, -1, nw);

    // Power-up full: nothing happens until afull_n=1 has passed the synchroniser.
    do_reset(1'b0, 1'b1);
    rem[0] = 4;
    tg = '{0, 0, 0, 0, 0, 0, 1};
    tw = '{0, 0, 0, 0, 0, 0, 1};
    td = '{0, 0, 0, 0, 0, 0, 0};
    run_tbl("pwrfull", -1, 4, nw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter/sequencer for the asynchronous-comparison FIFO, in the write-clock domain. Shares one FIFO write port among NREQ producers and limits each grant to a MAX_BURST-word burst. Synchronises the FIFO's asynchronous almost-full flag (afull_n) before use and stalls writes while it is low. Drives winc/wdata into the FIFO write-pointer logic.

Parameters:
NREQ, 4, number of requesters (≥2)
DSIZE, 8, data word width
MAX_BURST, 4, max words written per grant (≥1)
SYNC_STAGES, 2, flops in afull_n synchroniser (≥2)

Ports:
wclk  input  1  write-domain clock
dirclr_n  input  1  reset, asynchronous, active-low
req  input  NREQ  per-requester write request; level, held while data valid
wdata_in  input  NREQ*DSIZE  requester data; slice i = bits [i*DSIZE +: DSIZE]
afull_n  input  1  FIFO almost-full, active-low, asynchronous to wclk
gnt  output  NREQ  one-hot grant (all-zero when idle)
ack  output  NREQ  one-hot; word from requester i accepted this cycle
winc  output  1  FIFO write enable
wdata  output  DSIZE  FIFO write data
busy  output  1  high when state != IDLE

Behaviour:
- Reset (dirclr_n=0, immediate, no clock needed): state=IDLE, gnt=0, burst_cnt=0, prio_ptr=0, all sync flops=0; hence winc=0, ack=0, busy=0, wdata=0.
- afull_s = last stage of SYNC_STAGES flop chain on afull_n, reset 0 (treated as full). After reset release, no write before afull_n has propagated, ≥SYNC_STAGES cycles.
- System rule: FIFO integration asserts afull_n low with ≥SYNC_STAGES+1 free entries; the block needs no other overflow protection.
- States: IDLE, XFER, HOLD. gnt, owner, burst_cnt, prio_ptr registered.
- IDLE: if |req and afull_s=1 at edge, owner = first i with req[i]=1 scanning prio_ptr, prio_ptr+1, ... mod NREQ; gnt<=onehot(owner), burst_cnt<=0, -> XFER. Otherwise stay IDLE. No grant issued while afull_s=0.
- XFER: write condition W = req[owner] & afull_s (combinational). W=1: winc=1, ack[owner]=1, wdata=wdata_in slice owner, burst_cnt++.
  - W=1 and burst_cnt==MAX_BURST-1: -> IDLE, gnt<=0, prio_ptr<=owner+1 mod NREQ.
  - req[owner]=0: -> IDLE, gnt<=0, prio_ptr<=owner+1 mod NREQ; no write.
  - req[owner]=1, afull_s=0: -> HOLD; no write.
  - Otherwise stay XFER.
- HOLD: gnt held, winc=0, ack=0. afull_s=1 and req[owner]=1 -> XFER, burst_cnt kept. req[owner]=0 -> IDLE and prio_ptr update as above.
- Outside W: winc=0, ack=0, wdata=0 (no stale data).
- Latency: req rising in IDLE, afull_s=1 at edge k -> gnt and first winc/ack in cycle k+1. Between consecutive grants there is one IDLE cycle, so max throughput is MAX_BURST/(MAX_BURST+1).
- Fairness: a requester continuously asserting req waits at most (NREQ-1) bursts.
- Requesters sample ack on wclk and advance data on ack. Changes of req for non-owners during a burst are ignored until IDLE.
- afull_n glitches shorter than one wclk period may or may not be captured. Either outcome only delays writes and never drops or duplicates a word.
- Reset mid-burst: immediate return to reset values. The in-flight word is not acked and therefore not written.

Test Plan:
- Single requester: NREQ=4, req[2]=1 for 10 words, afull_n=1 -> bursts of 4,4,2 on gnt=0100; one idle cycle between bursts; winc count 10; data order preserved.
- Contention: req=1111 continuous, afull_n=1, after reset -> grant order 0,1,2,3,0; each burst exactly 4 winc; no cycle with two gnt bits.
- Almost-full stall: afull_n=0 after 2nd word of a burst -> winc=0 starting ≤SYNC_STAGES+1 cycles later, state HOLD with gnt kept. afull_n=1 -> remaining 2 words written, total 4.
- Early release: req[1] drops after 1 word -> IDLE next cycle, prio_ptr=2; pending req[0] and req[3] -> gnt to 3 first.
- Reset mid-burst: dirclr_n low during XFER -> gnt, winc, ack, busy = 0 same cycle. After release with afull_n=1, first winc no earlier than SYNC_STAGES+1 edges later.
- Power-up full: afull_n=0 at reset release, req=0001 -> no gnt/winc until afull_n=1 has been synchronised.
